softmax_seq: RTL and testbench

Parametrised job sequencer for the three-pass softmax datapath. It accepts a start/end address job and generates the on-chip memory read addresses for the max, subtract/exp/sum and normalise passes. It drives latency-aligned enables to each datapath stage and reports completion. It replaces the hard-wired `mode*_run` flag chain with a single FSM whose pipeline latencies are parameters, and it adds busy, error and write-address outputs.

---
 rtl/softmax_seq_pkg.sv | 43 ++++
 rtl/softmax_seq_delay.sv | 38 +++
 rtl/softmax_seq.sv | 119 +++++++++++
 tb/tb_softmax_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/softmax_seq_pkg.sv
// Shared definitions for the softmax job sequencer.
//   state_t   : sequencer FSM states
//   pass_t    : encoding driven on the 'pass' output
//   pass_of() : state -> pass encoding
//   wait_len(): length in cycles of each timed state, from the latency parameters
package softmax_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_P1, S_W1, S_P2, S_W2, S_LOG, S_P3, S_W3, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PASS_IDLE = 2'd0,
    PASS_MAX  = 2'd1,
    PASS_EXP  = 2'd2,
    PASS_NORM = 2'd3
  } pass_t;

  function automatic pass_t pass_of(input state_t s);
    case (s)
      S_P1, S_W1:        pass_of = PASS_MAX;
      S_P2, S_W2, S_LOG: pass_of = PASS_EXP;
      S_P3, S_W3:        pass_of = PASS_NORM;
      default:           pass_of = PASS_IDLE;
    endcase
  endfunction

  // Wait states cover the pipeline drain between passes; LOG adds one cycle
  // so the ln output register loads after the unit's full latency.
  function automatic logic [15:0] wait_len(input state_t s, input int rd_lat,
                                           input int max_lat, input int exp_lat,
                                           input int sum_lat, input int log_lat,
                                           input int norm_lat);
    case (s)
      S_W1:    wait_len = 16'(rd_lat + max_lat);
      S_W2:    wait_len = 16'(rd_lat + exp_lat + sum_lat);
      S_LOG:   wait_len = 16'(log_lat + 1);
      S_W3:    wait_len = 16'(rd_lat + norm_lat);
      default: wait_len = 16'd1;
    endcase
  endfunction

endpackage

// File: rtl/softmax_seq_delay.sv
// Fixed-depth delay line for a valid bit plus a data word.
//   clk      : rising-edge clock
//   flush_n  : synchronous active-low flush of all stages
//   in_vld / in_data   : stage-0 input
//   out_vld / out_data : input delayed by DEPTH cycles (DEPTH >= 1)
module softmax_seq_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         flush_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [DEPTH:1]        vld_pipe;
  logic [DEPTH:1][W-1:0] dat_pipe;

  always_ff @(posedge clk) begin
    if (!flush_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      dat_pipe[1] <= in_data;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[DEPTH];
  assign out_data = dat_pipe[DEPTH];

endmodule

// File: rtl/softmax_seq.sv
// Three-pass softmax job sequencer: max, sub/exp/sum, normalise.
// Ports:
//   clk, reset (sync, active low)
//   start, start_addr, end_addr : job request, accepted only in IDLE
//   rd_addr, rd_en, pass        : memory read stream and current pass
//   max_en, acc_en, acc_clr, log_en, out_valid, out_addr : datapath enables
//   busy, done, err             : job status (err pulses with done on end<start)
//   perf_cycles (16b)           : busy-cycle counter, only with SOFTMAX_SEQ_PERF_EN
module softmax_seq import softmax_seq_pkg::*; #(
  parameter int ADDRSIZE = 10,
  parameter int RD_LAT   = 1,
  parameter int MAX_LAT  = 2,
  parameter int EXP_LAT  = 3,
  parameter int SUM_LAT  = 2,
  parameter int LOG_LAT  = 4,
  parameter int NORM_LAT = 3
) (
`ifdef SOFTMAX_SEQ_PERF_EN
  output logic [15:0]         perf_cycles,
`endif
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDRSIZE-1:0] start_addr,
  input  logic [ADDRSIZE-1:0] end_addr,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic                rd_en,
  output logic [1:0]          pass,
  output logic                max_en,
  output logic                acc_en,
  output logic                acc_clr,
  output logic                log_en,
  output logic                out_valid,
  output logic [ADDRSIZE-1:0] out_addr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t                state;
  logic [ADDRSIZE-1:0]   addr, start_q, end_q;
  logic                  err_q;
  logic [15:0]           cnt;
  logic [ADDRSIZE-1:0]   unused_max_data, unused_acc_data;

  function automatic logic [15:0] wl(input state_t s);
    wl = wait_len(s, RD_LAT, MAX_LAT, EXP_LAT, SUM_LAT, LOG_LAT, NORM_LAT) - 16'd1;
  endfunction

  // Pass exit compares against end_q before incrementing, so end=2^N-1
  // never wraps the address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      addr    <= '0;
      start_q <= '0;
      end_q   <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          start_q <= start_addr;
          end_q   <= end_addr;
          addr    <= start_addr;
          err_q   <= (end_addr < start_addr);
          state   <= (end_addr < start_addr) ? S_DONE : S_P1;
        end
        S_P1: if (addr == end_q) begin state <= S_W1; cnt <= wl(S_W1); end
              else addr <= addr + 1'b1;
        S_W1: if (cnt == '0) begin state <= S_P2; addr <= start_q; end
              else cnt <= cnt - 16'd1;
        S_P2: if (addr == end_q) begin state <= S_W2; cnt <= wl(S_W2); end
              else addr <= addr + 1'b1;
        S_W2: if (cnt == '0) begin state <= S_LOG; cnt <= wl(S_LOG); end
              else cnt <= cnt - 16'd1;
        S_LOG: if (cnt == '0) begin state <= S_P3; addr <= start_q; end
               else cnt <= cnt - 16'd1;
        S_P3: if (addr == end_q) begin state <= S_W3; cnt <= wl(S_W3); end
              else addr <= addr + 1'b1;
        S_W3: if (cnt == '0) state <= S_DONE;
              else cnt <= cnt - 16'd1;
        S_DONE: begin state <= S_IDLE; err_q <= 1'b0; end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_en   = (state == S_P1) || (state == S_P2) || (state == S_P3);
  assign rd_addr = addr;
  assign pass    = pass_of(state);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign err     = done && err_q;
  // First P2 beat is the only P2 cycle where addr still equals start.
  assign acc_clr = (state == S_P2) && (addr == start_q);
  assign log_en  = (state == S_LOG) && (cnt == '0);

  softmax_seq_delay #(.DEPTH(RD_LAT), .W(ADDRSIZE)) u_max_dly (
    .clk(clk), .flush_n(reset), .in_vld(state == S_P1), .in_data(addr),
    .out_vld(max_en), .out_data(unused_max_data));

  softmax_seq_delay #(.DEPTH(RD_LAT + EXP_LAT), .W(ADDRSIZE)) u_acc_dly (
    .clk(clk), .flush_n(reset), .in_vld(state == S_P2), .in_data(addr),
    .out_vld(acc_en), .out_data(unused_acc_data));

  softmax_seq_delay #(.DEPTH(RD_LAT + NORM_LAT), .W(ADDRSIZE)) u_out_dly (
    .clk(clk), .flush_n(reset), .in_vld(state == S_P3), .in_data(addr),
    .out_vld(out_valid), .out_data(out_addr));

`ifdef SOFTMAX_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset)                          perf_cycles <= '0;
    else if (state == S_IDLE && start)   perf_cycles <= '0;
    else if (busy && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_softmax_seq.sv
module tb_softmax_seq;
  localparam int A = 10, RD = 1, MX = 2, EX = 3, SM = 2, LG = 4, NM = 3;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [A-1:0] start_addr = '0, end_addr = '0;
  logic [A-1:0] rd_addr, out_addr;
  logic [1:0]   pass;
  logic         rd_en, max_en, acc_en, acc_clr, log_en, out_valid, busy, done, err;
`ifdef SOFTMAX_SEQ_PERF_EN
  logic [15:0]  perf_cycles;
`endif

  int checks = 0, errors = 0;

  softmax_seq dut (
`ifdef SOFTMAX_SEQ_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .rd_addr(rd_addr), .rd_en(rd_en), .pass(pass),
    .max_en(max_en), .acc_en(acc_en), .acc_clr(acc_clr), .log_en(log_en),
    .out_valid(out_valid), .out_addr(out_addr), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic bit in_rng(input int c, input int s, input int l);
    return (c >= s) && (c < s + l);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " rd_en"}, rd_en, 0);     chk({tag, " rd_addr"}, rd_addr, 0);
    chk({tag, " pass"}, pass, 0);       chk({tag, " max_en"}, max_en, 0);
    chk({tag, " acc_en"}, acc_en, 0);   chk({tag, " acc_clr"}, acc_clr, 0);
    chk({tag, " log_en"}, log_en, 0);   chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_addr"}, out_addr, 0); chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);       chk({tag, " err"}, err, 0);
`ifdef SOFTMAX_SEQ_PERF_EN
    chk({tag, " perf"}, perf_cycles, 0);
`endif
  endtask

  // Schedule of a job, in cycles after the accepting edge T0.
  task automatic sched(input logic [A-1:0] sa, ea, output bit e, output int l,
                       output int p1, output int p2, output int p3, output int dn);
    e  = (ea < sa);
    l  = int'(ea) - int'(sa) + 1;
    p1 = 1;
    p2 = p1 + l + RD + MX;
    p3 = p2 + l + RD + EX + SM + LG + 1;
    dn = e ? 1 : p3 + l + RD + NM;
  endtask

  task automatic check_cycle(input logic [A-1:0] sa, ea, input int c);
    bit e; int l, p1, p2, p3, dn, ps;
    bit x_rd, x_max, x_acc, x_ov;
    int x_pass;
    string t;
    sched(sa, ea, e, l, p1, p2, p3, dn);
    t = $sformatf("[%0h..%0h c=%0d]", sa, ea, c);
    x_rd = 0; x_max = 0; x_acc = 0; x_ov = 0; ps = 0; x_pass = 0;
    if (!e) begin
      if (in_rng(c, p1, l)) begin x_rd = 1; ps = p1; x_pass = 1; end
      if (in_rng(c, p2, l)) begin x_rd = 1; ps = p2; x_pass = 2; end
      if (in_rng(c, p3, l)) begin x_rd = 1; ps = p3; x_pass = 3; end
      x_max = in_rng(c - RD, p1, l);
      x_acc = in_rng(c - RD - EX, p2, l);
      x_ov  = in_rng(c - RD - NM, p3, l);
    end
    chk({t, " busy"}, busy, (c >= 1 && c <= dn));
    chk({t, " done"}, done, (c == dn));
    chk({t, " err"}, err, (e && c == dn));
    chk({t, " rd_en"}, rd_en, x_rd);
    chk({t, " max_en"}, max_en, x_max);
    chk({t, " acc_en"}, acc_en, x_acc);
    chk({t, " out_valid"}, out_valid, x_ov);
    chk({t, " acc_clr"}, acc_clr, (!e && c == p2));
    chk({t, " log_en"}, log_en, (!e && c == p3 - 1));
    if (x_rd) begin
      chk({t, " rd_addr"}, rd_addr, (int'(sa) + c - ps) & 32'h3FF);
      chk({t, " pass"}, pass, x_pass);
    end
    if (c > dn) chk({t, " pass_idle"}, pass, 0);
    if (x_ov) chk({t, " out_addr"}, out_addr, (int'(sa) + c - RD - NM - p3) & 32'h3FF);
  endtask

  // poke_c: cycle to pulse a (to-be-ignored) start; rst_c: cycle to pull reset.
  task automatic run_job(input logic [A-1:0] sa, ea, input int poke_c, input int rst_c,
                         input bit chain, output int done_c);
    bit e; int l, p1, p2, p3, dn;
    sched(sa, ea, e, l, p1, p2, p3, dn);
    if (!chain) @(negedge clk);
    start = 1; start_addr = sa; end_addr = ea;
    done_c = -1;
    for (int c = 1; c <= dn + 1; c++) begin
      @(negedge clk);
      start = 0;
      check_cycle(sa, ea, c);
      if (done === 1'b1) done_c = c;
`ifdef SOFTMAX_SEQ_PERF_EN
      if (c == dn + 1) chk($sformatf("perf [%0h..%0h]", sa, ea), perf_cycles, dn);
`endif
      if (c == poke_c) begin start = 1; start_addr = '0; end_addr = 10'h3FF; end
      if (c == rst_c) begin
        reset = 0;
        @(negedge clk);
        chk_zero("after_mid_reset");
        reset = 1;
        done_c = -2;
        return;
      end
    end
  endtask

  typedef struct {
    logic [A-1:0] sa, ea;
    int           exp_done;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int dc;
    logic [A-1:0] sa, ea;
    vecs[0] = '{10'h010, 10'h013, 31};
    vecs[1] = '{10'h3FF, 10'h3FF, 22};
    vecs[2] = '{10'h020, 10'h01F, 1};
    vecs[3] = '{10'h000, 10'h000, 22};
    vecs[4] = '{10'h3F0, 10'h3FF, 67};
    vecs[5] = '{10'h3FF, 10'h000, 1};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1;

    foreach (vecs[i]) begin
      run_job(vecs[i].sa, vecs[i].ea, 0, 0, 0, dc);
      chk($sformatf("done_cycle vec%0d", i), dc, vecs[i].exp_done);
    end

    // start pulsed during P2 (P2 spans cycles 8..11) is ignored
    run_job(10'h010, 10'h013, 9, 0, 0, dc);
    chk("done_cycle start_in_p2", dc, 31);

    // reset in W2 (cycles 12..17), then the same job again
    run_job(10'h010, 10'h013, 0, 13, 0, dc);
    run_job(10'h010, 10'h013, 0, 0, 0, dc);
    chk("done_cycle after_reset", dc, 31);

    // back-to-back: start in the idle cycle right after DONE
    run_job(10'h100, 10'h102, 0, 0, 1, dc);
    chk("done_cycle chained", dc, 28);

    for (int k = 0; k < 20; k++) begin
      sa = A'($urandom_range(0, 1023));
      if (k % 5 == 4 && sa != 0) ea = sa - 1'b1;
      else ea = A'((int'(sa) + int'($urandom_range(0, 15)) > 1023) ? 1023
                   : int'(sa) + int'($urandom_range(0, 15)));
      if (ea < sa && (k % 5 != 4)) ea = sa;
      run_job(sa, ea, 0, 0, ($urandom_range(0, 1) == 1), dc);
      chk($sformatf("done_cycle rand%0d", k), dc,
          (ea < sa) ? 1 : 3 * (int'(ea) - int'(sa) + 1) + 19);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
